// File: rtl/cdb_arbiter_if.sv
// Common data bus bundle: per-source result requests in, grant and the
// registered broadcast out.
interface cdb_arbiter_if #(
  parameter int N_SRC     = 3,
  parameter int PTAG_W    = 7,
  parameter int ROB_TAG_W = 4,
  parameter int DATA_W    = 32
);
  localparam int SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [N_SRC-1:0]           req_valid_i;
  logic [N_SRC-1:0]           req_ready_o;
  logic [N_SRC*PTAG_W-1:0]    req_tag_i;
  logic [N_SRC*DATA_W-1:0]    req_data_i;
  logic [N_SRC*ROB_TAG_W-1:0] req_rob_tag_i;
  logic [N_SRC-1:0]           req_rd_used_i;

  logic                       cdb_valid_o;
  logic [PTAG_W-1:0]          cdb_tag_o;
  logic [DATA_W-1:0]          cdb_data_o;
  logic [ROB_TAG_W-1:0]       cdb_rob_tag_o;
  logic                       cdb_rd_used_o;
  logic [SRC_W-1:0]           cdb_src_o;

  // Execution-unit side: presents results, sees grants and the broadcast.
  modport master (
    output req_valid_i, req_tag_i, req_data_i, req_rob_tag_i, req_rd_used_i,
    input  req_ready_o,
    input  cdb_valid_o, cdb_tag_o, cdb_data_o, cdb_rob_tag_o, cdb_rd_used_o, cdb_src_o
  );

  // Arbiter side.
  modport slave (
    input  req_valid_i, req_tag_i, req_data_i, req_rob_tag_i, req_rd_used_i,
    output req_ready_o,
    output cdb_valid_o, cdb_tag_o, cdb_data_o, cdb_rob_tag_o, cdb_rd_used_o, cdb_src_o
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the single common data bus. One source is granted
// per cycle; its result is broadcast on registered cdb_* outputs next cycle.
module cdb_arbiter #(
  parameter int N_SRC     = 3,
  parameter int PTAG_W    = 7,
  parameter int ROB_TAG_W = 4,
  parameter int DATA_W    = 32,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  cdb_arbiter_if.slave     bus,
  output logic [CNT_W-1:0] perf_busy_o,
  output logic [CNT_W-1:0] perf_conflict_o
);
  localparam int SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam logic [SRC_W-1:0] LAST_SRC = SRC_W'(N_SRC - 1);

  logic [SRC_W-1:0] ptr;
  logic [SRC_W-1:0] gidx;
  logic [SRC_W-1:0] sel;
  logic             found;
  logic             grant;
  logic             conflict;

  // Scan from ptr upward with wrap; the first valid source wins. Reset and
  // flush suppress the grant so nothing is accepted that would be dropped.
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    sel   = '0;
    for (int k = 0; k < N_SRC; k++) begin
      sel = SRC_W'((int'(ptr) + k) % N_SRC);
      if (!found && bus.req_valid_i[sel]) begin
        found = 1'b1;
        gidx  = sel;
      end
    end
    grant    = found && rst_n && !flush_i;
    conflict = ($countones(bus.req_valid_i) >= 2) && !flush_i;
  end

  // One-hot grant back to the winning source.
  always_comb begin
    bus.req_ready_o = '0;
    if (grant) bus.req_ready_o[gidx] = 1'b1;
  end

  // Broadcast register, round-robin pointer and saturating perf counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr               <= '0;
      bus.cdb_valid_o   <= 1'b0;
      bus.cdb_tag_o     <= '0;
      bus.cdb_data_o    <= '0;
      bus.cdb_rob_tag_o <= '0;
      bus.cdb_rd_used_o <= 1'b0;
      bus.cdb_src_o     <= '0;
      perf_busy_o       <= '0;
      perf_conflict_o   <= '0;
    end else begin
      bus.cdb_valid_o <= grant;
      if (grant) begin
        // Payload holds when idle; consumers qualify with cdb_valid_o.
        bus.cdb_tag_o     <= bus.req_tag_i[gidx*PTAG_W +: PTAG_W];
        bus.cdb_data_o    <= bus.req_data_i[gidx*DATA_W +: DATA_W];
        bus.cdb_rob_tag_o <= bus.req_rob_tag_i[gidx*ROB_TAG_W +: ROB_TAG_W];
        bus.cdb_rd_used_o <= bus.req_rd_used_i[gidx];
        bus.cdb_src_o     <= gidx;
        ptr               <= (gidx == LAST_SRC) ? '0 : gidx + SRC_W'(1);
        if (perf_busy_o != '1) perf_busy_o <= perf_busy_o + CNT_W'(1);
      end
      if (conflict && perf_conflict_o != '1)
        perf_conflict_o <= perf_conflict_o + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios followed by a randomized phase,
// all compared against a distance-based round-robin reference model.
module tb_cdb_arbiter;
  localparam int N    = 3;
  localparam int PW   = 7;
  localparam int RW   = 4;
  localparam int DW   = 32;
  localparam int CW   = 4;
  localparam int SW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic [CW-1:0] perf_busy;
  logic [CW-1:0] perf_conf;

  always #5 clk = ~clk;

  cdb_arbiter_if #(.N_SRC(N), .PTAG_W(PW), .ROB_TAG_W(RW), .DATA_W(DW)) bus ();

  cdb_arbiter #(.N_SRC(N), .PTAG_W(PW), .ROB_TAG_W(RW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flush_i(flush),
    .bus(bus.slave),
    .perf_busy_o(perf_busy),
    .perf_conflict_o(perf_conf)
  );

  // Source-side request state (held until granted).
  logic          v  [N];
  logic [PW-1:0] tg [N];
  logic [DW-1:0] dt [N];
  logic [RW-1:0] rb [N];
  logic          ru [N];

  // Reference model state.
  int          m_ptr, m_src, m_busy, m_conf;
  logic        m_valid, m_ru;
  logic [PW-1:0] m_tag;
  logic [DW-1:0] m_data;
  logic [RW-1:0] m_rob;

  int n_checks = 0;
  int n_fail = 0;
  int last_g;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic req(input int i, input logic [PW-1:0] t, input logic [DW-1:0] d,
                     input logic [RW-1:0] r, input logic u);
    v[i] = 1'b1; tg[i] = t; dt[i] = d; rb[i] = r; ru[i] = u;
  endtask

  task automatic req_rand(input int i);
    req(i, PW'($urandom), $urandom, RW'($urandom), 1'($urandom));
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.req_valid_i[i]             = v[i];
      bus.req_tag_i[i*PW +: PW]      = tg[i];
      bus.req_data_i[i*DW +: DW]     = dt[i];
      bus.req_rob_tag_i[i*RW +: RW]  = rb[i];
      bus.req_rd_used_i[i]           = ru[i];
    end
  endtask

  // Winner = valid source with smallest forward distance from the pointer.
  function automatic int pick();
    int best = -1;
    int bd = N;
    if (!rst_n || flush) return -1;
    for (int i = 0; i < N; i++)
      if (v[i] && ((i - m_ptr + N) % N) < bd) begin
        bd = (i - m_ptr + N) % N;
        best = i;
      end
    return best;
  endfunction

  // One clock: called at negedge, drives inputs, checks grant, advances model
  // at the posedge and checks registered outputs at the following negedge.
  task automatic cyc();
    int g, pc;
    logic [N-1:0] exp_ready;
    drive();
    #1;
    g = pick();
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    chk("req_ready", 64'(bus.req_ready_o), 64'(exp_ready));
    pc = 0;
    for (int i = 0; i < N; i++) pc += int'(v[i]);
    @(posedge clk);
    if (!rst_n) begin
      m_ptr = 0; m_valid = 0; m_tag = '0; m_data = '0; m_rob = '0; m_ru = 0;
      m_src = 0; m_busy = 0; m_conf = 0;
    end else begin
      m_valid = (g >= 0);
      if (g >= 0) begin
        m_tag = tg[g]; m_data = dt[g]; m_rob = rb[g]; m_ru = ru[g]; m_src = g;
        m_ptr = (g + 1) % N;
        if (m_busy < CMAX) m_busy++;
        v[g] = 1'b0;
      end
      if (pc >= 2 && !flush && m_conf < CMAX) m_conf++;
    end
    last_g = g;
    @(negedge clk);
    chk("cdb_valid",   64'(bus.cdb_valid_o),   64'(m_valid));
    chk("cdb_tag",     64'(bus.cdb_tag_o),     64'(m_tag));
    chk("cdb_data",    64'(bus.cdb_data_o),    64'(m_data));
    chk("cdb_rob_tag", 64'(bus.cdb_rob_tag_o), 64'(m_rob));
    chk("cdb_rd_used", 64'(bus.cdb_rd_used_o), 64'(m_ru));
    chk("cdb_src",     64'(bus.cdb_src_o),     64'(m_src));
    chk("perf_busy",   64'(perf_busy),         64'(m_busy));
    chk("perf_conf",   64'(perf_conf),         64'(m_conf));
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      v[i] = 0; tg[i] = '0; dt[i] = '0; rb[i] = '0; ru[i] = 0;
    end
    m_ptr = 0; m_src = 0; m_busy = 0; m_conf = 0;
    m_valid = 0; m_ru = 0; m_tag = '0; m_data = '0; m_rob = '0;
    @(negedge clk);

    // Reset, including a request that must not be granted during reset.
    rst_n = 1'b0;
    cyc();
    req_rand(0);
    cyc();
    v[0] = 1'b0;
    cyc();
    chk("rst_cdb_valid", 64'(bus.cdb_valid_o), 64'd0);

    // Idle after release.
    rst_n = 1'b1;
    cyc();
    cyc();
    chk("idle_busy", 64'(perf_busy), 64'd0);

    // Single ALU request.
    req(0, 7'h12, 32'hDEADBEEF, 4'h3, 1'b1);
    cyc();
    chk("alu_tag",  64'(bus.cdb_tag_o),  64'h12);
    chk("alu_data", 64'(bus.cdb_data_o), 64'hDEADBEEF);
    chk("alu_src",  64'(bus.cdb_src_o),  64'd0);

    // Fresh reset, then all three held valid for six cycles from ptr=0.
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < N; i++) if (!v[i]) req_rand(i);
      cyc();
      chk("rr_order", 64'(bus.cdb_src_o), 64'(k % 3));
    end
    for (int i = 0; i < N; i++) v[i] = 1'b0;
    chk("rr_conflict", 64'(perf_conf), 64'd6);
    chk("rr_busy",     64'(perf_busy), 64'd6);

    // Move ptr to 2 via an LSU grant, then LSU+BRU: BRU first, then LSU.
    req_rand(1);
    cyc();
    req_rand(1);
    req_rand(2);
    cyc();
    chk("lb_first", 64'(bus.cdb_src_o), 64'd2);
    cyc();
    chk("lb_second", 64'(bus.cdb_src_o), 64'd1);
    chk("lb_nogap",  64'(bus.cdb_valid_o), 64'd1);

    // Flush with ALU valid: no grant, no broadcast; granted after flush drops.
    req_rand(0);
    flush = 1'b1;
    cyc();
    chk("flush_valid", 64'(bus.cdb_valid_o), 64'd0);
    flush = 1'b0;
    cyc();
    chk("post_flush_src",   64'(bus.cdb_src_o),   64'd0);
    chk("post_flush_valid", 64'(bus.cdb_valid_o), 64'd1);

    // BRU result that writes no register.
    req(2, 7'h55, 32'h0BAD_F00D, 4'hA, 1'b0);
    cyc();
    chk("bru_rd_used", 64'(bus.cdb_rd_used_o), 64'd0);
    chk("bru_rob",     64'(bus.cdb_rob_tag_o), 64'hA);

    // Randomized phase with flushes and occasional resets.
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N; i++) if (!v[i] && $urandom_range(0, 1) == 1) req_rand(i);
      flush = ($urandom_range(0, 9) == 0);
      rst_n = ($urandom_range(0, 49) != 0);
      cyc();
    end

    // Saturate both counters, then confirm they stay pinned after a grant.
    rst_n = 1'b1;
    flush = 1'b0;
    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < N; i++) if (!v[i]) req_rand(i);
      cyc();
    end
    for (int i = 0; i < N; i++) v[i] = 1'b0;
    chk("busy_sat", 64'(perf_busy), 64'(CMAX));
    chk("conf_sat", 64'(perf_conf), 64'(CMAX));
    req_rand(1);
    cyc();
    chk("busy_sat_hold", 64'(perf_busy), 64'(CMAX));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) between the completing execution units: ALU, LSU and BRU by default.
- Each cycle it grants at most one requester using round-robin priority, then broadcasts that result on a registered CDB output one cycle later.
- The CDB output feeds the dispatch/reservation-station wakeup, the PRF valid bits and ROB completion. It replaces the constant cdb_valid_i=0 tie-off in the OoO top.

Parameters:
- N_SRC, 3, number of requesting FUs; index 0=ALU, 1=LSU, 2=BRU.
- PTAG_W, 7, physical register tag width.
- ROB_TAG_W, 4, ROB tag width.
- DATA_W, 32, result data width.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- flush_i  in  1  pipeline flush; drops the in-flight broadcast.
- req_valid_i  in  N_SRC  result valid, one bit per source.
- req_ready_o  out  N_SRC  grant/accept, one bit per source.
- req_tag_i  in  N_SRC*PTAG_W  destination physical tag; source i occupies bits [i*PTAG_W +: PTAG_W].
- req_data_i  in  N_SRC*DATA_W  result data.
- req_rob_tag_i  in  N_SRC*ROB_TAG_W  ROB entry to mark complete.
- req_rd_used_i  in  N_SRC  result writes a register.
- cdb_valid_o  out  1  broadcast valid.
- cdb_tag_o  out  PTAG_W  broadcast physical tag.
- cdb_data_o  out  DATA_W  broadcast data.
- cdb_rob_tag_o  out  ROB_TAG_W  broadcast ROB tag.
- cdb_rd_used_o  out  1  broadcast writes PRF / wakes consumers.
- cdb_src_o  out  $clog2(N_SRC)  index of the granted source.
- perf_busy_o  out  CNT_W  cycles in which cdb_valid_o=1.
- perf_conflict_o  out  CNT_W  cycles with at least 2 valid requesters and no flush.

Behaviour:
- Reset (rst_n=0 at posedge): all outputs become 0, including cdb_valid_o, all cdb_* fields, both perf counters and the round-robin pointer (ptr=0). req_ready_o=0 while rst_n=0.
- Grant logic is combinational on req_valid_i and ptr.
  - Scan sources in order ptr, ptr+1, ..., wrapping modulo N_SRC. The first source with req_valid_i=1 gets req_ready_o=1; all others get 0.
  - req_ready_o is one-hot or zero. No source is granted without its own valid bit set.
  - Sources must hold valid and payload stable until they are granted. The arbiter never drops an ungranted request.
- Transfer occurs on valid & ready. At the next posedge the cdb_* registers load the granted source's payload, cdb_src_o is set and cdb_valid_o=1. Latency is exactly 1 cycle from grant to broadcast.
- If no source is granted, cdb_valid_o=0 next cycle. The cdb_* payload registers hold their previous values, and consumers must qualify them with cdb_valid_o.
- Throughput: 1 broadcast per cycle. Back-to-back grants to the same or different sources are allowed, and the CDB itself never stalls.
- Pointer update: after a grant to source g, ptr <= (g+1) mod N_SRC; it wraps from N_SRC-1 to 0. With no grant, ptr is unchanged.
  - Fairness guarantee: a continuously valid source is granted within N_SRC cycles.
- Flush (flush_i=1 in a cycle):
  - req_ready_o=0 for all sources in that cycle.
  - cdb_valid_o=0 at the next posedge.
  - ptr is unchanged.
  - A broadcast already visible on cdb_valid_o in the flush cycle still completes that cycle and is not retracted.
- A source with req_rd_used_i=0 (store, branch) is still broadcast with cdb_rd_used_o=0. Consumers use that result only for ROB completion.
- perf_busy_o increments at each posedge where the next cdb_valid_o=1.
- perf_conflict_o increments when popcount(req_valid_i)≥2 and flush_i=0.
- Both counters saturate at all-ones and never wrap.
- Reset asserted mid-operation overrides everything: any pending grant is discarded and no broadcast occurs in the following cycle.

Test Plan:
- Reset with all req_valid_i=0 → all outputs 0, ptr=0; after release with no requests, cdb_valid_o stays 0 and perf_busy_o=0.
- Single ALU request (tag=7'h12, data=32'hDEADBEEF, rob=4'h3, rd_used=1) → req_ready_o=3'b001 that cycle; next cycle cdb_valid_o=1, cdb_tag_o=7'h12, cdb_data_o=32'hDEADBEEF, cdb_rob_tag_o=4'h3, cdb_src_o=0.
- All three valid and held for 6 cycles, starting from ptr=0 → grant order 0,1,2,0,1,2; perf_conflict_o=6; perf_busy_o=6 one cycle after the last grant.
- LSU and BRU valid with ptr=2 → BRU granted first, then LSU; cdb_src_o sequence 2,1; no gap in cdb_valid_o.
- flush_i=1 in the same cycle ALU is valid → req_ready_o=0, next cycle cdb_valid_o=0; ALU, still held valid, is granted in the cycle after flush deasserts.
- BRU result with rd_used=0, rob=4'hA → broadcast with cdb_rd_used_o=0, cdb_rob_tag_o=4'hA; perf counters forced to the all-ones value stay saturated after a further grant.
